pdp8_iot_master: RTL and testbench

CPU-side initiator for the PDP-8 programmed-I/O bus. It turns a decoded IOT instruction (6ddo) into a single-cycle bus request to peripherals such as the teletype, then samples their skip/set-AC/read-data/acknowledge responses and returns the result to the CPU core. It also implements device 00 itself: the interrupt enable flip-flop with the one-instruction ION delay, interrupt request gating, and CAF.

---
 rtl/pdp8_iot_master_if.sv | 38 +++
 rtl/pdp8_iot_master.sv | 216 +++++++++++++++++++++
 tb/tb_pdp8_iot_master.sv | 376 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pdp8_iot_master_if.sv
// -----------------------------------------------------------------------------
// pdp8_iot_master_if
//   PDP-8 programmed-I/O bus between the CPU-side IOT initiator and the
//   peripherals (teletype etc.).
//
//   master -> slave : io_dev   (6)  device address
//                     io_op    (3)  operation code
//                     io_req   (1)  one-cycle strobe qualifying dev/op/wdata
//                     io_wdata (12) AC to device
//                     io_caf   (1)  one-cycle clear-all-flags pulse
//   slave -> master : io_rdata (12) wired-OR read data
//                     io_sac   (1)  load AC from io_rdata
//                     io_skip  (1)  skip response
//                     io_ack   (1)  device acknowledge
//                     io_irq   (1)  OR of device interrupt requests
// -----------------------------------------------------------------------------
interface pdp8_iot_master_if;
    logic [5:0]  io_dev;
    logic [2:0]  io_op;
    logic        io_req;
    logic [11:0] io_wdata;
    logic        io_caf;
    logic [11:0] io_rdata;
    logic        io_sac;
    logic        io_skip;
    logic        io_ack;
    logic        io_irq;

    modport master (
        output io_dev, io_op, io_req, io_wdata, io_caf,
        input  io_rdata, io_sac, io_skip, io_ack, io_irq
    );

    modport slave (
        input  io_dev, io_op, io_req, io_wdata, io_caf,
        output io_rdata, io_sac, io_skip, io_ack, io_irq
    );
endinterface

// File: rtl/pdp8_iot_master.sv
// -----------------------------------------------------------------------------
// pdp8_iot_master
//   CPU-side initiator for PDP-8 IOT instructions (6ddo). External devices get
//   a single-cycle io_req strobe and their responses are sampled in that same
//   cycle. Device 00 is handled locally: interrupt enable with the
//   one-instruction ION delay, SKON/ION/IOF/SRQ/CAF and interrupt request
//   gating. Fixed latency: start (cycle 0) -> ISSUE (cycle 1) -> done (cycle 2).
//
//   clk, rst      clock; synchronous active-high reset
//   start         one-cycle request to execute instr (ignored while busy)
//   instr[8:0]    [8:3] device, [2:0] op
//   ac_in[11:0]   AC captured at start
//   insn_end      pulse at the end of every instruction (clocks the ION delay)
//   int_ack       CPU is taking the interrupt
//   busy          IOT issuing on the bus
//   done          one-cycle completion pulse; ac_out/ac_load/skip/noack valid
//   int_en        interrupt enable flip-flop
//   int_req       interrupt request to the CPU
//   bus           programmed-I/O bus (master side)
// -----------------------------------------------------------------------------
module pdp8_iot_master (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [8:0]  instr,
    input  logic [11:0] ac_in,
    input  logic        insn_end,
    input  logic        int_ack,
    output logic        busy,
    output logic        done,
    output logic [11:0] ac_out,
    output logic        ac_load,
    output logic        skip,
    output logic        noack,
    output logic        int_en,
    output logic        int_req,
    pdp8_iot_master_if.master bus
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ISSUE    = 2'd1,
        S_COMPLETE = 2'd2
    } state_e;

    localparam logic [2:0] OP_SKON = 3'd0;
    localparam logic [2:0] OP_ION  = 3'd1;
    localparam logic [2:0] OP_IOF  = 3'd2;
    localparam logic [2:0] OP_SRQ  = 3'd3;
    localparam logic [2:0] OP_CAF  = 3'd7;

    state_e      state_q, state_d;
    logic [5:0]  dev_q, dev_d;
    logic [2:0]  op_q, op_d;
    logic [11:0] ac_q, ac_d;
    // Results are resolved during ISSUE and presented during COMPLETE.
    logic        res_skip_q, res_skip_d;
    logic        res_load_q, res_load_d;
    logic [11:0] res_ac_q, res_ac_d;
    logic        res_noack_q, res_noack_d;
    logic        int_en_q, int_en_d;
    logic [1:0]  delay_q, delay_d;

    // NOTE: the reset here is synchronous, so it sits inside the clocked branch
    // rather than in the sensitivity list.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            dev_q       <= '0;
            op_q        <= '0;
            ac_q        <= '0;
            res_skip_q  <= 1'b0;
            res_load_q  <= 1'b0;
            res_ac_q    <= '0;
            res_noack_q <= 1'b0;
            int_en_q    <= 1'b0;
            delay_q     <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // from before this edge, independent of statement order.
            state_q     <= state_d;
            dev_q       <= dev_d;
            op_q        <= op_d;
            ac_q        <= ac_d;
            res_skip_q  <= res_skip_d;
            res_load_q  <= res_load_d;
            res_ac_q    <= res_ac_d;
            res_noack_q <= res_noack_d;
            int_en_q    <= int_en_d;
            delay_q     <= delay_d;
        end
    end

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_d     = state_q;
        dev_d       = dev_q;
        op_d        = op_q;
        ac_d        = ac_q;
        res_skip_d  = res_skip_q;
        res_load_d  = res_load_q;
        res_ac_d    = res_ac_q;
        res_noack_d = res_noack_q;
        int_en_d    = int_en_q;
        delay_d     = delay_q;

        busy    = 1'b0;
        done    = 1'b0;
        ac_out  = '0;
        ac_load = 1'b0;
        skip    = 1'b0;
        noack   = 1'b0;

        // Address/data hold their last command; only io_req qualifies them.
        bus.io_dev   = dev_q;
        bus.io_op    = op_q;
        bus.io_wdata = ac_q;
        bus.io_req   = 1'b0;
        bus.io_caf   = 1'b0;

        // ION delay: counts instruction ends; the 1->0 step enables interrupts.
        if (insn_end && delay_q != 2'd0) begin
            delay_d = delay_q - 2'd1;
            if (delay_q == 2'd1) begin
                int_en_d = 1'b1;
            end
        end

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    dev_d   = instr[8:3];
                    op_d    = instr[2:0];
                    ac_d    = ac_in;
                    state_d = S_ISSUE;
                end
            end

            S_ISSUE: begin
                busy    = 1'b1;
                state_d = S_COMPLETE;
                if (dev_q != 6'd0) begin
                    // Responders are combinational, so their answer is
                    // available within this single strobe cycle.
                    bus.io_req  = 1'b1;
                    res_noack_d = ~bus.io_ack;
                    res_skip_d  = bus.io_ack & bus.io_skip;
                    res_load_d  = bus.io_ack & bus.io_sac;
                    res_ac_d    = bus.io_sac ? bus.io_rdata : ac_q;
                end else begin
                    res_noack_d = 1'b0;
                    res_skip_d  = 1'b0;
                    res_load_d  = 1'b0;
                    res_ac_d    = ac_q;
                    unique case (op_q)
                        OP_SKON: begin
                            res_skip_d = int_en_q;
                            int_en_d   = 1'b0;
                            delay_d    = 2'd0;
                        end
                        OP_ION: begin
                            delay_d = 2'd2;
                        end
                        OP_IOF: begin
                            int_en_d = 1'b0;
                            delay_d  = 2'd0;
                        end
                        OP_SRQ: begin
                            res_skip_d = bus.io_irq;
                        end
                        OP_CAF: begin
                            bus.io_caf = 1'b1;
                            int_en_d   = 1'b0;
                            delay_d    = 2'd0;
                            res_load_d = 1'b1;
                            res_ac_d   = '0;
                        end
                        default: ;
                    endcase
                end
            end

            S_COMPLETE: begin
                // busy is already low here: the next IOT may start in the
                // same cycle its predecessor reports done.
                done    = 1'b1;
                skip    = res_skip_q;
                ac_load = res_load_q;
                ac_out  = res_ac_q;
                noack   = res_noack_q;
                if (start) begin
                    dev_d   = instr[8:3];
                    op_d    = instr[2:0];
                    ac_d    = ac_in;
                    state_d = S_ISSUE;
                end else begin
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase

        // Taking the interrupt overrides everything, including a delay that
        // would expire in this very cycle.
        if (int_ack) begin
            int_en_d = 1'b0;
            delay_d  = 2'd0;
        end
    end

    assign int_en  = int_en_q;
    assign int_req = int_en_q & bus.io_irq & (delay_q == 2'd0);

endmodule

// File: tb/tb_pdp8_iot_master.sv
// -----------------------------------------------------------------------------
// tb_pdp8_iot_master
//   Table of IOT vectors, hand-written multi-cycle sequences for the interrupt
//   system and abort/overlap cases, then randomized IOTs checked against a
//   behavioural model (interrupt enable plus "instructions until enable").
// -----------------------------------------------------------------------------
module tb_pdp8_iot_master;

    logic        clk;
    logic        rst;
    logic        start;
    logic [8:0]  instr;
    logic [11:0] ac_in;
    logic        insn_end;
    logic        int_ack;
    logic        busy;
    logic        done;
    logic [11:0] ac_out;
    logic        ac_load;
    logic        skip;
    logic        noack;
    logic        int_en;
    logic        int_req;

    pdp8_iot_master_if bus ();

    pdp8_iot_master dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .instr    (instr),
        .ac_in    (ac_in),
        .insn_end (insn_end),
        .int_ack  (int_ack),
        .busy     (busy),
        .done     (done),
        .ac_out   (ac_out),
        .ac_load  (ac_load),
        .skip     (skip),
        .noack    (noack),
        .int_en   (int_en),
        .int_req  (int_req),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Peripheral responder: answers combinationally, only while strobed.
    logic        r_ack, r_sac, r_skp, r_irq;
    logic [11:0] r_rdata;

    always_comb begin
        bus.io_ack   = bus.io_req & r_ack;
        bus.io_sac   = bus.io_req & r_sac;
        bus.io_skip  = bus.io_req & r_skp;
        bus.io_rdata = bus.io_req ? r_rdata : 12'd0;
        bus.io_irq   = r_irq;
    end

    int n_cmp = 0;
    int n_err = 0;

    // Interrupt model: enable bit and number of instruction ends still to
    // elapse before interrupts become enabled (0 = nothing pending).
    logic m_en   = 1'b0;
    int   m_wait = 0;

    typedef struct packed {
        logic        req;
        logic        caf;
        logic        skp;
        logic        load;
        logic [11:0] acout;
        logic        noack;
    } exp_t;

    typedef struct packed {
        logic [8:0]  ins;
        logic [11:0] ac;
        logic        ack;
        logic        sac;
        logic        skp;
        logic [11:0] rdata;
        logic        irq;
        exp_t        e;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0o, expected %0o", name, act, exp);
        end
    endtask

    function automatic vec_t mkv(input logic [8:0] ins, input logic [11:0] ac,
                                 input logic ack, input logic sac, input logic skp,
                                 input logic [11:0] rdata, input logic irq,
                                 input logic e_req, input logic e_caf, input logic e_skp,
                                 input logic e_load, input logic [11:0] e_ac,
                                 input logic e_noack);
        vec_t v;
        v.ins = ins;  v.ac = ac;  v.ack = ack;  v.sac = sac;  v.skp = skp;
        v.rdata = rdata;  v.irq = irq;
        v.e.req = e_req;  v.e.caf = e_caf;  v.e.skp = e_skp;
        v.e.load = e_load;  v.e.acout = e_ac;  v.e.noack = e_noack;
        return v;
    endfunction

    // Expected IOT result from the instruction's documented meaning.
    function automatic exp_t predict(input vec_t v);
        exp_t e;
        e = '0;
        if (v.ins[8:3] != 6'd0) begin
            e.req   = 1'b1;
            e.noack = !v.ack;
            e.skp   = v.ack && v.skp;
            e.load  = v.ack && v.sac;
            e.acout = v.rdata;
        end else begin
            case (v.ins[2:0])
                3'd0: e.skp = m_en;
                3'd3: e.skp = v.irq;
                3'd7: begin e.caf = 1'b1; e.load = 1'b1; e.acout = 12'd0; end
                default: ;
            endcase
        end
        return e;
    endfunction

    // Apply device-00 side effects to the interrupt model.
    task automatic model_iot(input logic [8:0] ins);
        if (ins[8:3] == 6'd0) begin
            case (ins[2:0])
                3'd0, 3'd2, 3'd7: begin m_en = 1'b0; m_wait = 0; end
                3'd1: m_wait = 2;
                default: ;
            endcase
        end
    endtask

    // One cycle with optional instruction-end / interrupt-ack pulses, then
    // compare the interrupt outputs against the model.
    task automatic tick(input logic ie, input logic ia);
        insn_end = ie;
        int_ack  = ia;
        @(posedge clk); #1;
        insn_end = 1'b0;
        int_ack  = 1'b0;
        if (ia) begin
            m_en = 1'b0; m_wait = 0;
        end else if (ie && m_wait > 0) begin
            m_wait--;
            if (m_wait == 0) m_en = 1'b1;
        end
        check("int_en", {31'd0, int_en}, {31'd0, m_en});
        check("int_req", {31'd0, int_req}, {31'd0, m_en & r_irq & (m_wait == 0)});
    endtask

    // Run one IOT (start in current cycle) and compare ISSUE and COMPLETE.
    task automatic iot_check(input string tag, input vec_t v);
        r_ack = v.ack;  r_sac = v.sac;  r_skp = v.skp;  r_rdata = v.rdata;  r_irq = v.irq;
        start = 1'b1;  instr = v.ins;  ac_in = v.ac;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, " issue io_req"}, {31'd0, bus.io_req}, {31'd0, v.e.req});
        check({tag, " issue io_caf"}, {31'd0, bus.io_caf}, {31'd0, v.e.caf});
        check({tag, " issue busy"}, {31'd0, busy}, 32'd1);
        check({tag, " issue done"}, {31'd0, done}, 32'd0);
        if (v.e.req) begin
            check({tag, " io_dev"}, {26'd0, bus.io_dev}, {26'd0, v.ins[8:3]});
            check({tag, " io_op"}, {29'd0, bus.io_op}, {29'd0, v.ins[2:0]});
            check({tag, " io_wdata"}, {20'd0, bus.io_wdata}, {20'd0, v.ac});
        end
        model_iot(v.ins);
        @(posedge clk); #1;
        check({tag, " done"}, {31'd0, done}, 32'd1);
        check({tag, " io_req after"}, {31'd0, bus.io_req}, 32'd0);
        check({tag, " io_caf after"}, {31'd0, bus.io_caf}, 32'd0);
        check({tag, " skip"}, {31'd0, skip}, {31'd0, v.e.skp});
        check({tag, " ac_load"}, {31'd0, ac_load}, {31'd0, v.e.load});
        check({tag, " noack"}, {31'd0, noack}, {31'd0, v.e.noack});
        if (v.e.load) check({tag, " ac_out"}, {20'd0, ac_out}, {20'd0, v.e.acout});
        check({tag, " int_en"}, {31'd0, int_en}, {31'd0, m_en});
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " busy"}, {31'd0, busy}, 32'd0);
        check({tag, " done"}, {31'd0, done}, 32'd0);
        check({tag, " ac_out"}, {20'd0, ac_out}, 32'd0);
        check({tag, " ac_load"}, {31'd0, ac_load}, 32'd0);
        check({tag, " skip"}, {31'd0, skip}, 32'd0);
        check({tag, " noack"}, {31'd0, noack}, 32'd0);
        check({tag, " int_en"}, {31'd0, int_en}, 32'd0);
        check({tag, " int_req"}, {31'd0, int_req}, 32'd0);
        check({tag, " io_req"}, {31'd0, bus.io_req}, 32'd0);
        check({tag, " io_caf"}, {31'd0, bus.io_caf}, 32'd0);
        check({tag, " io_dev"}, {26'd0, bus.io_dev}, 32'd0);
        check({tag, " io_op"}, {29'd0, bus.io_op}, 32'd0);
        check({tag, " io_wdata"}, {20'd0, bus.io_wdata}, 32'd0);
    endtask

    // Enable interrupts through the normal ION sequence.
    task automatic enable_ints();
        vec_t v;
        v = mkv(9'o001, 12'o0, 0, 0, 0, 12'o0, r_irq, 0, 0, 0, 0, 12'o0, 0);
        iot_check("ion", v);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
    endtask

    vec_t vecs [11];

    initial begin
        int n_req, n_done;
        vec_t v;

        rst = 1'b1;  start = 1'b0;  instr = '0;  ac_in = '0;
        insn_end = 1'b0;  int_ack = 1'b0;
        r_ack = 1'b0;  r_sac = 1'b0;  r_skp = 1'b0;  r_rdata = '0;  r_irq = 1'b1;

        //            ins     ac       ack sac skp rdata    irq  req caf skp load acout   noack
        vecs[0]  = mkv(9'o036, 12'o0000, 1, 1, 0, 12'o0301, 0,   1,  0,  0,  1,  12'o0301, 0); // KRB
        vecs[1]  = mkv(9'o041, 12'o1234, 1, 0, 1, 12'o0000, 0,   1,  0,  1,  0,  12'o0000, 0); // TSF
        vecs[2]  = mkv(9'o041, 12'o1234, 0, 0, 1, 12'o0000, 0,   1,  0,  0,  0,  12'o0000, 1); // TSF no ack
        vecs[3]  = mkv(9'o036, 12'o0000, 0, 1, 0, 12'o0301, 0,   1,  0,  0,  0,  12'o0000, 1); // KRB no ack
        vecs[4]  = mkv(9'o046, 12'o7070, 1, 0, 0, 12'o0000, 0,   1,  0,  0,  0,  12'o0000, 0); // TLS
        vecs[5]  = mkv(9'o123, 12'o0001, 1, 1, 1, 12'o7777, 0,   1,  0,  1,  1,  12'o7777, 0); // skip+load
        vecs[6]  = mkv(9'o003, 12'o0000, 0, 0, 0, 12'o0000, 0,   0,  0,  0,  0,  12'o0000, 0); // SRQ irq=0
        vecs[7]  = mkv(9'o003, 12'o0000, 0, 0, 0, 12'o0000, 1,   0,  0,  1,  0,  12'o0000, 0); // SRQ irq=1
        vecs[8]  = mkv(9'o007, 12'o5555, 1, 1, 1, 12'o1111, 0,   0,  1,  0,  1,  12'o0000, 0); // CAF
        vecs[9]  = mkv(9'o004, 12'o4321, 1, 1, 1, 12'o1111, 1,   0,  0,  0,  0,  12'o0000, 0); // op 4
        vecs[10] = mkv(9'o002, 12'o0000, 0, 0, 0, 12'o0000, 1,   0,  0,  0,  0,  12'o0000, 0); // IOF

        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;
        tick(1'b0, 1'b0);

        for (int i = 0; i < 11; i++) begin
            iot_check($sformatf("vec%0d", i), vecs[i]);
            tick(1'b0, 1'b0);
        end

        // ION delay: disabled until the instruction after ION has ended.
        r_irq = 1'b1;
        v = mkv(9'o001, 12'o0, 0, 0, 0, 12'o0, 1, 0, 0, 0, 0, 12'o0, 0);
        iot_check("ion seq", v);
        check("ion pre en", {31'd0, int_en}, 32'd0);
        tick(1'b1, 1'b0);
        check("ion after 1st end en", {31'd0, int_en}, 32'd0);
        check("ion after 1st end req", {31'd0, int_req}, 32'd0);
        tick(1'b1, 1'b0);
        check("ion after 2nd end en", {31'd0, int_en}, 32'd1);
        check("ion after 2nd end req", {31'd0, int_req}, 32'd1);
        tick(1'b0, 1'b1);
        check("int_ack clears en", {31'd0, int_en}, 32'd0);

        // ION while already enabled keeps int_en set.
        enable_ints();
        v = mkv(9'o001, 12'o0, 0, 0, 0, 12'o0, 1, 0, 0, 0, 0, 12'o0, 0);
        iot_check("ion again", v);
        check("ion again en", {31'd0, int_en}, 32'd1);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        check("ion again settled en", {31'd0, int_en}, 32'd1);

        // SKON with interrupts enabled: skip, then disabled.
        v = mkv(9'o000, 12'o0, 0, 0, 0, 12'o0, 1, 0, 0, 1, 0, 12'o0, 0);
        iot_check("skon", v);
        check("skon clears en", {31'd0, int_en}, 32'd0);
        tick(1'b0, 1'b0);

        // CAF with interrupts enabled.
        enable_ints();
        v = mkv(9'o007, 12'o3456, 0, 0, 0, 12'o0, 1, 0, 1, 0, 1, 12'o0, 0);
        iot_check("caf en", v);
        check("caf clears en", {31'd0, int_en}, 32'd0);
        tick(1'b0, 1'b0);

        // IOF during a pending delay cancels it.
        v = mkv(9'o001, 12'o0, 0, 0, 0, 12'o0, 1, 0, 0, 0, 0, 12'o0, 0);
        iot_check("ion pend", v);
        tick(1'b1, 1'b0);
        v = mkv(9'o002, 12'o0, 0, 0, 0, 12'o0, 1, 0, 0, 0, 0, 12'o0, 0);
        iot_check("iof pend", v);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        check("iof cancels delay", {31'd0, int_en}, 32'd0);

        // int_ack on the same cycle as the expiring insn_end wins.
        v = mkv(9'o001, 12'o0, 0, 0, 0, 12'o0, 1, 0, 0, 0, 0, 12'o0, 0);
        iot_check("ion race", v);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b1);
        check("ack vs expiry en", {31'd0, int_en}, 32'd0);
        tick(1'b1, 1'b0);
        check("ack vs expiry later en", {31'd0, int_en}, 32'd0);

        // start held into ISSUE is dropped: exactly one strobe and one done.
        r_ack = 1'b1;  r_sac = 1'b0;  r_skp = 1'b0;
        n_req = 0;  n_done = 0;
        start = 1'b1;  instr = 9'o036;  ac_in = 12'o0;
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk); #1;
            n_req  += int'(bus.io_req);
            n_done += int'(done);
            if (c == 1) begin
                start = 1'b1;  instr = 9'o041;
            end else begin
                start = 1'b0;
            end
            if (c == 2) check("busy start io_dev held", {26'd0, bus.io_dev}, 32'o03);
        end
        check("busy start req count", n_req, 1);
        check("busy start done count", n_done, 1);

        // Back-to-back: start accepted in the done cycle.
        start = 1'b1;  instr = 9'o036;  ac_in = 12'o0;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        check("b2b first done", {31'd0, done}, 32'd1);
        start = 1'b1;  instr = 9'o046;  ac_in = 12'o0525;
        @(posedge clk); #1;
        start = 1'b0;
        check("b2b second req", {31'd0, bus.io_req}, 32'd1);
        check("b2b second dev", {26'd0, bus.io_dev}, 32'o04);
        check("b2b second wdata", {20'd0, bus.io_wdata}, 32'o0525);
        @(posedge clk); #1;
        check("b2b second done", {31'd0, done}, 32'd1);
        tick(1'b0, 1'b0);

        // Reset during ISSUE aborts the IOT.
        enable_ints();
        r_sac = 1'b1;  r_rdata = 12'o7654;
        start = 1'b1;  instr = 9'o036;  ac_in = 12'o1111;
        @(posedge clk); #1;
        start = 1'b0;
        check("abort issue req", {31'd0, bus.io_req}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_en = 1'b0;  m_wait = 0;
        check_all_zero("abort");
        n_done = 0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            n_done += int'(done);
        end
        check("abort no done", n_done, 0);

        // Randomized IOTs with interleaved instruction ends and acks.
        for (int i = 0; i < 150; i++) begin
            v.ins   = ($urandom_range(0, 1) == 0) ? {6'd0, 3'($urandom_range(0, 7))}
                                                  : {6'($urandom_range(1, 63)), 3'($urandom_range(0, 7))};
            v.ac    = 12'($urandom);
            v.ack   = ($urandom_range(0, 3) != 0);
            v.sac   = 1'($urandom);
            v.skp   = 1'($urandom);
            v.rdata = 12'($urandom);
            v.irq   = 1'($urandom);
            v.e     = predict(v);
            iot_check($sformatf("rand%0d", i), v);
            for (int k = 0; k < int'($urandom_range(1, 3)); k++) begin
                tick(1'($urandom), ($urandom_range(0, 7) == 0));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
